// File: rtl/buffered_io_port_if.sv
// -----------------------------------------------------------------------------
// buffered_io_port_if
// Bundles the datapath-bus and device handshake signals of buffered_io_port.
//   slave  : the port block itself (buffered_io_port)
//   master : whatever drives it (control unit / device model)
// Signals:
//   bus_in        datapath bus value to push into the output FIFO
//   OutPortIn     push bus_in into the output FIFO this edge
//   InPortOut     CPU read of the input holding register (consumes the word)
//   in_port_data  holding register contents, to the bus mux
//   in_avail      holding register contains an unread word
//   out_full      output FIFO full
//   out_empty     output FIFO empty
//   out_count     output FIFO occupancy, 0..DEPTH
//   out_ovf       sticky overflow flag
//   ovf_clr       synchronous clear of out_ovf
//   dev_out_data  FIFO head (first-word fall-through)
//   dev_out_valid FIFO head valid
//   dev_out_ready device accepts the head this edge
//   dev_in_data   device input word
//   dev_in_valid  device offers dev_in_data
//   dev_in_ready  holding register can accept a word this edge
// -----------------------------------------------------------------------------
interface buffered_io_port_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] bus_in;
   logic             OutPortIn;
   logic             InPortOut;
   logic [WIDTH-1:0] in_port_data;
   logic             in_avail;
   logic             out_full;
   logic             out_empty;
   logic [CW-1:0]    out_count;
   logic             out_ovf;
   logic             ovf_clr;
   logic [WIDTH-1:0] dev_out_data;
   logic             dev_out_valid;
   logic             dev_out_ready;
   logic [WIDTH-1:0] dev_in_data;
   logic             dev_in_valid;
   logic             dev_in_ready;

   modport slave (
      input  bus_in, OutPortIn, InPortOut, ovf_clr,
             dev_out_ready, dev_in_data, dev_in_valid,
      output in_port_data, in_avail, out_full, out_empty, out_count,
             out_ovf, dev_out_data, dev_out_valid, dev_in_ready
   );

   modport master (
      output bus_in, OutPortIn, InPortOut, ovf_clr,
             dev_out_ready, dev_in_data, dev_in_valid,
      input  in_port_data, in_avail, out_full, out_empty, out_count,
             out_ovf, dev_out_data, dev_out_valid, dev_in_ready
   );
endinterface

// File: rtl/buffered_io_port.sv
// -----------------------------------------------------------------------------
// buffered_io_port
// Buffered in/out port pair on the datapath bus.
//   Output channel: OutPortIn pushes bus_in into a DEPTH-entry first-word
//   fall-through FIFO that the device drains over dev_out_valid/dev_out_ready.
//   Input channel: a handshaked holding register loaded from the device and
//   read by the CPU via InPortOut, with in_avail status.
// Ports:
//   Clock    system clock, rising edge
//   Clear    asynchronous active-low reset
//   loop_en  (only with BUFFERED_IO_PORT_LOOPBACK_EN) route the FIFO head into
//            the holding register instead of the device paths
//   bus      buffered_io_port_if.slave, all bus and device handshake signals
// Optional feature macro: BUFFERED_IO_PORT_LOOPBACK_EN
// -----------------------------------------------------------------------------
module buffered_io_port #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic Clock,
   input  logic Clear,
`ifdef BUFFERED_IO_PORT_LOOPBACK_EN
   input  logic loop_en,
`endif
   buffered_io_port_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);

   // FIFO storage is deliberately left out of reset; only pointers/count are cleared.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             avail_q, avail_d;
   logic [WIDTH-1:0] hold_q, hold_d;

   logic             full;
   logic             empty;
   logic             in_ready;
   logic             pop;
   logic             push;
   logic             ovf_set;
   logic             capture;
   logic             loop_act;
   logic [WIDTH-1:0] head_data;
   logic [WIDTH-1:0] cap_data;

`ifdef BUFFERED_IO_PORT_LOOPBACK_EN
   assign loop_act = loop_en;
`else
   assign loop_act = 1'b0;
`endif

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign head_data = mem_q[rd_ptr_q];

   // The holding register can take a word when it is empty or being read now.
   assign in_ready  = !avail_q || bus.InPortOut;

   // In loopback the holding register is the consumer of the FIFO head.
   assign pop       = !empty && (loop_act ? in_ready : bus.dev_out_ready);

   // A pop on the same edge frees the slot, so a push into a full FIFO is accepted.
   assign push      = bus.OutPortIn && (!full || pop);
   assign ovf_set   = bus.OutPortIn && full && !pop;

   assign capture   = loop_act ? pop : (bus.dev_in_valid && in_ready);
   assign cap_data  = loop_act ? head_data : bus.dev_in_data;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      avail_d  = avail_q;
      hold_d   = hold_q;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      // Set has priority over clear.
      if (ovf_set)          ovf_d = 1'b1;
      else if (bus.ovf_clr) ovf_d = 1'b0;

      // A capture on the same edge as a read keeps the flag set with the new word.
      if (capture) begin
         hold_d  = cap_data;
         avail_d = 1'b1;
      end else if (bus.InPortOut) begin
         avail_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         avail_q  <= 1'b0;
         hold_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         avail_q  <= avail_d;
         hold_q   <= hold_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (push) mem_q[wr_ptr_q] <= bus.bus_in;
   end

   assign bus.in_port_data  = hold_q;
   assign bus.in_avail      = avail_q;
   assign bus.out_full      = full;
   assign bus.out_empty     = empty;
   assign bus.out_count     = count_q;
   assign bus.out_ovf       = ovf_q;
   assign bus.dev_out_data  = head_data;
   assign bus.dev_out_valid = !empty && !loop_act;
   assign bus.dev_in_ready  = in_ready && !loop_act;
endmodule
